// File: rtl/axis_segment_inserter_dyn_if.sv
// AXI-Stream bus bundle used on both sides of the segment inserter.
interface axis_segment_inserter_dyn_if #(
  parameter int DATA_W = 64
) ();
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_segment_inserter_dyn.sv
// Inserts a per-packet side-channel segment at a fixed byte offset of an
// AXI-Stream packet, with a registered output, tail flush and insert counter.
module axis_segment_inserter_dyn #(
  parameter int AXIS_BUS_WIDTH    = 64,
  parameter int INSERT_SIZE_BYTES = 4,
  parameter int INSERT_OFFSET     = 12,
  parameter int CNT_WIDTH         = 32
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  axis_segment_inserter_dyn_if.slave     s_axis,
  input  logic [INSERT_SIZE_BYTES*8-1:0] seg_tdata,
  input  logic                           seg_insert,
  input  logic                           seg_valid,
  output logic                           seg_ready,
  axis_segment_inserter_dyn_if.master    m_axis,
  output logic [CNT_WIDTH-1:0]           inserted_count
);
  localparam int W  = AXIS_BUS_WIDTH;
  localparam int NB = W/8;
  localparam int L  = NB/2;
  localparam int SL = INSERT_SIZE_BYTES/2;
  localparam int SW = SL*16;
  localparam int CW = W + SW;
  localparam int OL = INSERT_OFFSET/2;
  localparam int LW = $clog2(L+SL+1);
  localparam int PW = $clog2(OL+L+1)+1;

  typedef enum logic [2:0] {IDLE, HEAD, SHIFT, FLUSH, BYPASS} state_t;
  state_t state, state_nx;

  logic [SW-1:0] seg_q, hold, sg;
  logic [LW-1:0] hcnt, vl, ccnt;
  logic [PW-1:0] pos, rel, p;
  logic [W-1:0]  din_m, nx_tdata;
  logic [NB-1:0] nx_tkeep;
  logic [CW-1:0] din_x, lomask, comb_x;
  logic          nx_tlast, nx_ins, out_ins;
  logic          ld_ok, in_fire, head_mode, ins_here, do_shift, spill;

  function automatic logic [NB-1:0] keep_of(input logic [LW-1:0] n);
    for (int i = 0; i < NB; i++) keep_of[i] = (i/2 < int'(n));
  endfunction

  // One lane mux serves both cases: the insertion beat splices the segment
  // at lane p, and a SHIFT beat splices the holdover at lane 0.
  always_comb begin : datapath
    ld_ok = !m_axis.tvalid || m_axis.tready;
    vl    = LW'($countones(s_axis.tkeep) / 2);
    for (int i = 0; i < NB; i++)
      din_m[i*8 +: 8] = s_axis.tkeep[i] ? s_axis.tdata[i*8 +: 8] : 8'h00;
    head_mode = (state == HEAD) || (state == IDLE && seg_insert);
    rel       = (state == IDLE) ? PW'(OL) : PW'(OL) - pos;
    ins_here  = head_mode && ((rel < PW'(vl)) || (rel == PW'(vl) && s_axis.tlast));
    do_shift  = ins_here || (state == SHIFT);
    sg        = (state == SHIFT) ? hold : (state == IDLE) ? seg_tdata : seg_q;
    p         = (state == SHIFT) ? '0 : rel;
    din_x     = CW'(din_m);
    lomask    = ~({CW{1'b1}} << {p, 4'b0000});
    comb_x    = (din_x & lomask) | (CW'(sg) << {p, 4'b0000}) | ((din_x & ~lomask) << SW);
    ccnt      = vl + LW'(SL);
    spill     = ccnt > LW'(L);

    nx_tdata = din_m;
    nx_tkeep = keep_of(vl);
    nx_tlast = s_axis.tlast;
    nx_ins   = 1'b0;
    if (state == FLUSH) begin
      nx_tdata = W'(hold);
      nx_tkeep = keep_of(hcnt);
      nx_tlast = 1'b1;
      nx_ins   = 1'b1;
    end else if (do_shift) begin
      nx_tdata = comb_x[W-1:0];
      nx_tkeep = keep_of(spill ? LW'(L) : ccnt);
      nx_tlast = s_axis.tlast && !spill;
      nx_ins   = 1'b1;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin : next_state
    state_nx = state;
    case (state)
      IDLE, HEAD, SHIFT:
        if (in_fire) begin
          if (state == IDLE && !seg_insert) state_nx = s_axis.tlast ? IDLE : BYPASS;
          else if (s_axis.tlast)            state_nx = (do_shift && spill) ? FLUSH : IDLE;
          else                              state_nx = do_shift ? SHIFT : HEAD;
        end
      FLUSH:   if (ld_ok) state_nx = IDLE;
      BYPASS:  if (in_fire && s_axis.tlast) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A packet may only start once its descriptor is present.
  always_comb begin : handshake
    s_axis.tready = 1'b0;
    if (aresetn && ld_ok) begin
      case (state)
        IDLE:    s_axis.tready = seg_valid;
        FLUSH:   s_axis.tready = 1'b0;
        default: s_axis.tready = 1'b1;
      endcase
    end
    in_fire   = s_axis.tvalid && s_axis.tready;
    seg_ready = (state == IDLE) && in_fire;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      seg_q <= '0;
      pos   <= '0;
      hold  <= '0;
      hcnt  <= '0;
    end else if (in_fire) begin
      if (state == IDLE) seg_q <= seg_tdata;
      if (head_mode) pos <= ((state == IDLE) ? '0 : pos) + PW'(L);
      if (do_shift) begin
        hold <= comb_x[CW-1:W];
        hcnt <= spill ? ccnt - LW'(L) : '0;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis.tvalid  <= 1'b0;
      m_axis.tdata   <= '0;
      m_axis.tkeep   <= '0;
      m_axis.tlast   <= 1'b0;
      out_ins        <= 1'b0;
      inserted_count <= '0;
    end else begin
      if (ld_ok) begin
        m_axis.tvalid <= in_fire || (state == FLUSH);
        if (in_fire || state == FLUSH) begin
          m_axis.tdata <= nx_tdata;
          m_axis.tkeep <= nx_tkeep;
          m_axis.tlast <= nx_tlast;
          out_ins      <= nx_ins;
        end
      end
      if (m_axis.tvalid && m_axis.tready && m_axis.tlast && out_ins)
        inserted_count <= inserted_count + CNT_WIDTH'(1);
    end
  end
endmodule

// File: doc/axis_segment_inserter_dyn.md
Name: axis_segment_inserter_dyn

Overview:
- Complete AXI-Stream datapath that inserts an INSERT_SIZE_BYTES segment at byte INSERT_OFFSET of each packet, for example a VLAN tag at byte 12. It generalises the static inserter FSM.
- Segment contents and an insert/bypass decision are supplied per packet on a handshaked side channel.
- The block provides a registered output stage, tail-overflow flush beat, short-packet handling and an inserted-packet counter.
- Sits between the MAC-side ingress FIFO and the egress arbiter in the NMU.

Parameters:
- AXIS_BUS_WIDTH, 64: data width in bits; multiple of 16, at least 32.
- INSERT_SIZE_BYTES, 4: segment length; even, 2..AXIS_BUS_WIDTH/8.
- INSERT_OFFSET, 12: packet byte index where the segment starts; even, at least 0.
- CNT_WIDTH, 32: width of the inserted-packet counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous active-low reset
- s_axis_tdata  in  AXIS_BUS_WIDTH  input data; byte 0 = bits [7:0] = first on wire
- s_axis_tkeep  in  AXIS_BUS_WIDTH/8  contiguous from bit 0; 2-byte-lane granular
- s_axis_tlast  in  1  end of packet
- s_axis_tvalid  in  1  input valid
- s_axis_tready  out  1  input ready
- seg_tdata  in  INSERT_SIZE_BYTES*8  segment; bits [7:0] land at packet byte INSERT_OFFSET
- seg_insert  in  1  1 = insert, 0 = pass packet unmodified
- seg_valid  in  1  segment descriptor valid
- seg_ready  out  1  descriptor consumed
- m_axis_tdata  out  AXIS_BUS_WIDTH  output data
- m_axis_tkeep  out  AXIS_BUS_WIDTH/8  output keep
- m_axis_tlast  out  1  output last
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- inserted_count  out  CNT_WIDTH  packets that had a segment inserted; wraps

Behaviour:
- Reset is synchronous on aclk when aresetn=0. It clears m_axis_tvalid, m_axis_tdata, m_axis_tkeep, m_axis_tlast, s_axis_tready, seg_ready, inserted_count, the holdover register and the state (to IDLE).
- Reset mid-packet discards the partial packet. The next accepted beat is treated as the start of a packet.
- Output is a single register stage; latency is 1 cycle from input accept to m_axis_tvalid.
  - The register may load when it is empty or m_axis_tready=1 (full-throughput pipeline).
- seg_ready pulses for exactly 1 cycle, coincident with acceptance of the first beat of each packet.
- In IDLE, s_axis_tready=0 while seg_valid=0. A packet never starts without a descriptor. The descriptor is latched on the first beat.

State machine:
- IDLE: waiting for the first beat.
- HEAD: beats before or containing the insertion point; the lane mux is a pure function of beat index, as in the static FSM.
- SHIFT: every output beat = holdover lanes (INSERT_SIZE_BYTES/2 lanes from the previous input beat) followed by the leading lanes of the current input.
- FLUSH: one extra output beat carrying only the holdover, with tlast=1. s_axis_tready=0 during FLUSH.
- BYPASS: copy input to output unchanged.

Transitions:
- IDLE -> BYPASS if seg_insert=0, else IDLE -> HEAD.
- HEAD -> SHIFT once the beat containing segment byte INSERT_SIZE_BYTES-1 has been emitted.
- SHIFT or HEAD with tlast -> FLUSH if the current beat's valid lanes plus holdover lanes exceed the bus, else -> IDLE.
- FLUSH -> IDLE when the flush beat is accepted.
- BYPASS with tlast -> IDLE.
- Back-to-back packets run with no idle cycle, except that a FLUSH costs one cycle.

Short packets:
- Insertion happens iff the packet length is at least INSERT_OFFSET. Length exactly INSERT_OFFSET appends the segment at the tail.
- If tlast arrives with length < INSERT_OFFSET, the packet passes unmodified and inserted_count does not increment.
- The descriptor is still consumed.

Other rules:
- Output tkeep is contiguous from bit 0 and equals 2*(valid lanes); bytes beyond tkeep are driven to 0.
- inserted_count increments by 1 on acceptance of the output tlast beat of each inserted packet. It wraps at 2^CNT_WIDTH.
- All handshakes follow AXI-Stream: data, keep and last are held stable while valid=1 and ready=0.

Test Plan:
- 64-byte packet (8 beats), seg_insert=1, seg_tdata=0x0A006481, m_tready=1 -> 9 output beats; output bytes 12..15 = 81 64 00 0A; input bytes 12..63 appear at 16..67; last tkeep=0x0F; inserted_count=1.
- 60-byte packet (last input tkeep=0x0F), insert -> 8 output beats, last tkeep=0xFF, no FLUSH; next packet's first beat is accepted the cycle after the last input beat.
- 64-byte packet, seg_insert=0 -> 8 beats identical to input; inserted_count unchanged; seg_ready pulses once.
- 10-byte packet (tkeep 0xFF, then 0x03 with tlast), insert -> unchanged 10 bytes; inserted_count unchanged. Separately, a 12-byte packet -> 16 bytes with the segment at 12..15.
- seg_valid=0 for 5 cycles with s_tvalid=1 -> s_tready=0 throughout. Separately, m_tready toggling pseudo-randomly (50%) over 20 packets -> byte-exact match to the reference model, with no beat lost or duplicated.
- aresetn=0 for 1 cycle during beat 3 of an inserted packet -> all outputs 0 the next cycle. The following packet is processed correctly from beat 0.
